// File: rtl/sap_pkg.sv
// Shared SAP definitions: bus/opcode widths, two-word opcode base,
// assembly FSM state encoding and classic SAP-1 opcode constants.
package sap_pkg;

   localparam int DEF_WORD_W = 8;
   localparam int DEF_OP_W   = 4;
   localparam logic [3:0] DEF_EXT_BASE = 4'hC;

   typedef enum logic {
      S_OPC = 1'b0,
      S_OPR = 1'b1
   } asm_state_t;

   localparam logic [3:0] OPC_LDA = 4'h0;
   localparam logic [3:0] OPC_ADD = 4'h1;
   localparam logic [3:0] OPC_SUB = 4'h2;
   localparam logic [3:0] OPC_OUT = 4'hE;
   localparam logic [3:0] OPC_HLT = 4'hF;

endpackage

// File: rtl/ir_fifo.sv
// Decoded-instruction FIFO: storage, pointers, count, push/pop/flush.
// Ports: clk, clr (async low), push, pop, flush, wdata -> head, full, empty.
module ir_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A pop frees the slot a same-cycle push needs when full.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instruction_queue_reg.sv
// Instruction queue register: assembles 1/2-word instructions from the
// W-bus and queues them. Ports: clk, clr, data_in, li, ei, next, flush
// -> data_out, seq, valid, full, partial, ovf.
import sap_pkg::*;

module instruction_queue_reg #(
   parameter int WORD_W = DEF_WORD_W,
   parameter int OP_W   = DEF_OP_W,
   parameter int DEPTH  = 4,
   parameter logic [OP_W-1:0] EXT_BASE = OP_W'(DEF_EXT_BASE)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [WORD_W-1:0] data_in,
   input  logic              li,
   input  logic              ei,
   input  logic              next,
   input  logic              flush,
   output logic [WORD_W-1:0] data_out,
   output logic [OP_W-1:0]   seq,
   output logic              valid,
   output logic              full,
   output logic              partial,
   output logic              ovf
);

   localparam int EW = OP_W + WORD_W;
   localparam int SW = WORD_W - OP_W;

   asm_state_t      state;
   asm_state_t      state_n;
   logic [OP_W-1:0] opc_q;
   logic [OP_W-1:0] opc_n;
   logic            ovf_n;
   logic [OP_W-1:0] opc;
   logic            room;
   logic            push_req;
   logic [EW-1:0]   entry;
   logic [EW-1:0]   head;
   logic            empty;

   assign opc  = data_in[WORD_W-1 -: OP_W];
   assign room = !full || (next && valid);

   ir_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push_req),
      .pop   (next),
      .flush (flush),
      .wdata (entry),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= S_OPC;
         opc_q <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         opc_q <= opc_n;
         ovf   <= ovf_n;
      end
   end

   // A dropped word leaves the FSM where it was so it can be retried.
   always_comb begin
      state_n  = state;
      opc_n    = opc_q;
      ovf_n    = ovf;
      push_req = 1'b0;
      entry    = '0;
      if (flush) begin
         state_n = S_OPC;
      end else if (li) begin
         unique case (state)
            S_OPC: begin
               if (opc >= EXT_BASE) begin
                  opc_n   = opc;
                  state_n = S_OPR;
               end else begin
                  push_req = 1'b1;
                  entry    = {opc, {OP_W{1'b0}}, data_in[SW-1:0]};
                  if (!room) ovf_n = 1'b1;
               end
            end
            S_OPR: begin
               push_req = 1'b1;
               entry    = {opc_q, data_in};
               if (room) state_n = S_OPC;
               else      ovf_n   = 1'b1;
            end
            default: state_n = S_OPC;
         endcase
      end
   end

   assign valid    = !empty;
   assign partial  = (state == S_OPR);
   assign seq      = valid ? head[EW-1 -: OP_W] : '0;
   assign data_out = (ei && valid) ? head[WORD_W-1:0] : '0;

endmodule

// File: tb/tb_instruction_queue_reg.sv
// Self-checking bench for instruction_queue_reg: directed steps then
// random traffic against a queue-based model of the instruction rules.
module tb_instruction_queue_reg;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] data_in = '0;
   logic       li = 1'b0;
   logic       ei = 1'b0;
   logic       next = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] data_out;
   logic [3:0] seq;
   logic       valid;
   logic       full;
   logic       partial;
   logic       ovf;

   int errors = 0;
   int checks = 0;

   logic [11:0] q[$];
   bit          m_part;
   logic [3:0]  m_opc;
   bit          m_ovf;

   instruction_queue_reg dut (
      .clk      (clk),
      .clr      (clr),
      .data_in  (data_in),
      .li       (li),
      .ei       (ei),
      .next     (next),
      .flush    (flush),
      .data_out (data_out),
      .seq      (seq),
      .valid    (valid),
      .full     (full),
      .partial  (partial),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_part = 0;
      m_opc  = '0;
      m_ovf  = 0;
   endtask

   task automatic model_edge(bit l, bit n, bit f, logic [7:0] d);
      bit          have;
      bit          opr;
      bit          pop_ok;
      logic [11:0] e;
      have = 0;
      opr  = 0;
      e    = '0;
      if (f) begin
         q.delete();
         m_part = 0;
         return;
      end
      pop_ok = n && (q.size() > 0);
      if (l) begin
         if (!m_part) begin
            if (d[7:4] < 4'hC) begin
               have = 1;
               e = {d[7:4], 4'h0, d[3:0]};
            end else begin
               m_part = 1;
               m_opc  = d[7:4];
            end
         end else begin
            have = 1;
            opr  = 1;
            e    = {m_opc, d};
         end
      end
      if (pop_ok) void'(q.pop_front());
      if (have) begin
         if (q.size() < 4) begin
            q.push_back(e);
            if (opr) m_part = 0;
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   task automatic chk_model(string tag);
      bit          v;
      logic [11:0] h;
      v = q.size() != 0;
      h = v ? q[0] : 12'h0;
      chk({tag, ".valid"}, 32'(valid), 32'(v));
      chk({tag, ".full"}, 32'(full), 32'(q.size() == 4));
      chk({tag, ".partial"}, 32'(partial), 32'(m_part));
      chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
      chk({tag, ".seq"}, 32'(seq), v ? 32'(h[11:8]) : 0);
      chk({tag, ".dout"}, 32'(data_out), (v && ei) ? 32'(h[7:0]) : 0);
   endtask

   task automatic step(string tag, bit l, bit e, bit n, bit f,
                       logic [7:0] d);
      li      = l;
      ei      = e;
      next    = n;
      flush   = f;
      data_in = d;
      @(posedge clk);
      model_edge(l, n, f, d);
      #1;
      chk_model(tag);
   endtask

   task automatic do_reset(string tag);
      clr   = 1'b0;
      li    = 0;
      next  = 0;
      flush = 0;
      #1;
      model_clear();
      chk({tag, ".valid"}, 32'(valid), 0);
      chk({tag, ".full"}, 32'(full), 0);
      chk({tag, ".partial"}, 32'(partial), 0);
      chk({tag, ".ovf"}, 32'(ovf), 0);
      chk({tag, ".seq"}, 32'(seq), 0);
      chk({tag, ".dout"}, 32'(data_out), 0);
      #2;
      clr = 1'b1;
   endtask

   initial begin
      ei = 1'b1;
      do_reset("rst0");

      step("t2.li", 1, 1, 0, 0, 8'h1E);
      chk("t2.seq", 32'(seq), 32'h1);
      chk("t2.dout", 32'(data_out), 32'h0E);
      step("t2.pop", 0, 1, 1, 0, 8'h00);
      chk("t2.valid", 32'(valid), 0);

      step("t3.w1", 1, 1, 0, 0, 8'hC0);
      chk("t3.partial", 32'(partial), 1);
      chk("t3.valid", 32'(valid), 0);
      step("t3.w2", 1, 1, 0, 0, 8'hA5);
      chk("t3.seq", 32'(seq), 32'hC);
      chk("t3.dout", 32'(data_out), 32'hA5);
      chk("t3.partial2", 32'(partial), 0);
      step("t3.pop", 0, 1, 1, 0, 8'h00);

      for (int i = 1; i <= 5; i++) begin
         step("t4.push", 1, 1, 0, 0, 8'(i * 17));
         if (i == 4) chk("t4.full", 32'(full), 1);
      end
      chk("t4.ovf", 32'(ovf), 1);
      for (int i = 1; i <= 4; i++) begin
         chk("t4.order", 32'(seq), 32'(i));
         step("t4.pop", 0, 1, 1, 0, 8'h00);
      end
      chk("t4.empty", 32'(valid), 0);

      do_reset("rst1");
      for (int i = 1; i <= 4; i++)
         step("t5.fill", 1, 1, 0, 0, 8'h30 + 8'(i));
      step("t5.both", 1, 1, 1, 0, 8'h3A);
      chk("t5.full", 32'(full), 1);
      chk("t5.ovf", 32'(ovf), 0);
      chk("t5.head", 32'(data_out), 32'h02);
      for (int i = 0; i < 3; i++)
         step("t5.pop", 0, 1, 1, 0, 8'h00);
      chk("t5.tail", 32'(data_out), 32'h0A);
      step("t5.last", 0, 1, 1, 0, 8'h00);

      step("t6.w1", 1, 1, 0, 0, 8'h11);
      step("t6.w2", 1, 1, 0, 0, 8'hC3);
      chk("t6.partial", 32'(partial), 1);
      step("t6.flush", 1, 1, 1, 1, 8'h77);
      chk("t6.valid", 32'(valid), 0);
      chk("t6.partial2", 32'(partial), 0);
      step("t6.li", 1, 1, 0, 0, 8'h2F);
      chk("t6.seq", 32'(seq), 32'h2);
      chk("t6.dout", 32'(data_out), 32'h0F);
      step("t6.pop", 0, 1, 1, 0, 8'h00);

      step("t1.a", 1, 1, 0, 0, 8'h45);
      step("t1.b", 1, 1, 0, 0, 8'h56);
      step("t1.c", 1, 1, 0, 0, 8'hD9);
      chk("t1.partial", 32'(partial), 1);
      do_reset("t1.rst");

      for (int i = 0; i < 400; i++) begin
         step("rnd",
              $urandom_range(1) == 1,
              $urandom_range(1) == 1,
              $urandom_range(9) < 4,
              $urandom_range(19) == 0,
              8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
